// File: rtl/timer_sched_pkg.sv
// Shared types for the timer scheduler: FSM state encoding and id-width helper.
package timer_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_DONE} sched_state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr+1, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  int idx;

  // Scan from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        valid = 1'b1;
        id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one 1-second Timer among N_REQ requesters, round-robin, counting whole seconds per grant.
// Optional macro SCHED_ABORT_EN: dropping req of the current owner during ARM/WAIT aborts the job.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SEC_W = 8,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*SEC_W-1:0] sec,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [ID_W-1:0]        cur_id,
  output logic                   tmr_en,
  input  logic                   tmr_notify,
  output sched_state_t           state
);

  // Handshake: a requester raises req (level) and holds it; gnt[i] pulses once when the job
  // is accepted, done[i] pulses once when its seconds have elapsed; req may then drop.
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  sched_state_t     next_state;
  logic [ID_W-1:0]  ptr;
  logic [SEC_W-1:0] remain;
  logic [SEC_W-1:0] sec_sel;
  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  logic             abort;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .id    (pick_id)
  );

  assign sec_sel = sec[int'(pick_id)*SEC_W +: SEC_W];

`ifdef SCHED_ABORT_EN
  assign abort = ((state == S_ARM) || (state == S_WAIT)) && !req[cur_id];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (pick_valid) next_state = (sec_sel == '0) ? S_DONE : S_ARM;
      S_ARM:  next_state = S_WAIT;
      S_WAIT: if (tmr_notify) next_state = (remain == SEC_W'(1)) ? S_DONE : S_ARM;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  // tmr_en is registered from next_state so it is high exactly while the FSM sits in ARM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= ID_W'(N_REQ - 1);
      remain <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      cur_id <= '0;
      tmr_en <= 1'b0;
    end else begin
      state  <= next_state;
      gnt    <= '0;
      done   <= '0;
      tmr_en <= (next_state == S_ARM);
      case (state)
        S_IDLE: begin
          busy <= pick_valid;
          if (pick_valid) begin
            gnt    <= ONE << pick_id;
            cur_id <= pick_id;
            remain <= sec_sel;
          end
        end
        S_WAIT: if (tmr_notify) remain <= remain - SEC_W'(1);
        S_DONE: begin
          done <= ONE << cur_id;
          ptr  <= cur_id;
        end
        default: ;
      endcase
      if (abort) begin
        busy <= 1'b0;
        ptr  <= cur_id;
      end
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with a behavioural 1-second Timer (CLK_FREQ=16).
module tb_timer_scheduler;
  import timer_sched_pkg::*;

  localparam int N_REQ    = 4;
  localparam int SEC_W    = 8;
  localparam int CLK_FREQ = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*SEC_W-1:0] sec = '0;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [1:0]             cur_id;
  logic                   tmr_en;
  logic                   tmr_notify = 1'b0;
  sched_state_t           state;

  int tests = 0;
  int fails = 0;

  timer_scheduler #(.N_REQ(N_REQ), .SEC_W(SEC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .sec        (sec),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .cur_id     (cur_id),
    .tmr_en     (tmr_en),
    .tmr_notify (tmr_notify),
    .state      (state)
  );

  // ---------------- clock / Timer model ----------------
  always #5 clk = ~clk;

  logic [4:0] t_cnt = '0;
  logic       t_run = 1'b0;
  always @(posedge clk) begin
    if (tmr_en) begin
      t_cnt      <= '0;
      t_run      <= 1'b1;
      tmr_notify <= 1'b0;
    end else if (t_run) begin
      if (t_cnt == 5'(CLK_FREQ - 1)) begin
        tmr_notify <= 1'b1;
        t_run      <= 1'b0;
      end else begin
        t_cnt <= t_cnt + 5'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    sec = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_sec(input int i, input int v);
    sec[i*SEC_W +: SEC_W] = SEC_W'(v);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state_wait(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (state == S_WAIT) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '1;
    @(negedge clk);
    tests++;
    if ({gnt, done, busy, cur_id, tmr_en} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got gnt=%b done=%b busy=%b cur_id=%0d tmr_en=%b, want all 0",
               gnt, done, busy, cur_id, tmr_en);
    end
    tests++;
    if (state !== S_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d want %0d", state, S_IDLE);
    end
    req = '0;
  endtask

  task automatic test_single();
    int en_cnt, done_cnt, last_n, done_c, c;
    bit got_done, busy_gap;
    logic [N_REQ-1:0] done_val;
    do_reset();
    set_sec(1, 3);
    req = 4'b0010;
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0010 || cur_id !== 2'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_gnt: got gnt=%b cur_id=%0d busy=%b want 0010/1/1", gnt, cur_id, busy);
    end
    en_cnt = int'(tmr_en); done_cnt = 0; last_n = -100; done_c = 0;
    got_done = 0; busy_gap = 0; done_val = '0;
    for (c = 1; c < 400 && !got_done; c++) begin
      @(negedge clk);
      en_cnt += int'(tmr_en);
      if (busy !== 1'b1) busy_gap = 1;
      if (done != '0) begin
        got_done = 1; done_cnt++; done_val = done; done_c = c; req = '0;
      end else if (state == S_WAIT && tmr_notify) last_n = c;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      en_cnt += int'(tmr_en);
      if (done != '0) done_cnt++;
    end
    tests++;
    if (!got_done || done_val !== 4'b0010) begin
      fails++;
      $display("FAIL single_done: got seen=%0d done=%b want 1/0010", got_done, done_val);
    end
    tests++;
    if (done_c - last_n != 2) begin
      fails++;
      $display("FAIL single_latency: got %0d cycles after last notify want 2", done_c - last_n);
    end
    tests++;
    if (en_cnt != 3) begin
      fails++;
      $display("FAIL single_tmr_en: got %0d pulses want 3", en_cnt);
    end
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL single_done_count: got %0d want 1", done_cnt);
    end
    tests++;
    if (busy_gap || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy: got gap=%0d final=%b want 0/0", busy_gap, busy);
    end
  endtask

  task automatic test_zero_sec();
    int en_cnt;
    do_reset();
    set_sec(2, 0);
    req = 4'b0100;
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      fails++;
      $display("FAIL zero_gnt: got gnt=%b busy=%b want 0100/1", gnt, busy);
    end
    en_cnt = int'(tmr_en);
    @(negedge clk);
    en_cnt += int'(tmr_en);
    tests++;
    if (done !== 4'b0100 || busy !== 1'b1) begin
      fails++;
      $display("FAIL zero_done: got done=%b busy=%b want 0100/1", done, busy);
    end
    req = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      en_cnt += int'(tmr_en);
    end
    tests++;
    if (en_cnt != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_tmr_en: got pulses=%0d busy=%b want 0/0", en_cnt, busy);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int k;
    bit outstanding;
    logic [N_REQ-1:0] last_g;
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_sec(i, 1);
    req = 4'b1111;
    k = 0; outstanding = 0; last_g = '0;
    for (int c = 0; c < 2000 && !(k == 5 && !outstanding); c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        tests++;
        if (gnt !== (4'b0001 << order[k]) || outstanding) begin
          fails++;
          $display("FAIL rr_gnt%0d: got gnt=%b outstanding=%0d want %b/0",
                   k, gnt, outstanding, 4'b0001 << order[k]);
        end
        last_g = gnt; outstanding = 1; k++;
      end
      if (done != '0) begin
        tests++;
        if (done !== last_g) begin
          fails++;
          $display("FAIL rr_done%0d: got %b want %b", k, done, last_g);
        end
        outstanding = 0;
        if (k == 5) req = '0;
      end
    end
    tests++;
    if (k != 5 || outstanding) begin
      fails++;
      $display("FAIL rr_complete: got %0d grants outstanding=%0d want 5/0", k, outstanding);
    end
    req = '0;
  endtask

  task automatic test_ptr_wrap();
    bit ok;
    logic [N_REQ-1:0] g;
    do_reset();
    set_sec(3, 1);
    set_sec(0, 1);
    req = 4'b1000;
    @(negedge clk);
    g = gnt;
    wait_done(ok);
    req = 4'b1001;
    tests++;
    if (g !== 4'b1000 || !ok) begin
      fails++;
      $display("FAIL wrap_first: got gnt=%b done_seen=%0d want 1000/1", g, ok);
    end
    g = '0;
    for (int c = 0; c < 10 && g == '0; c++) begin
      @(negedge clk);
      g = gnt;
    end
    tests++;
    if (g !== 4'b0001) begin
      fails++;
      $display("FAIL wrap_second: got gnt=%b want 0001", g);
    end
    req = 4'b0001;
    wait_done(ok);
    req = '0;
  endtask

  task automatic test_rst_mid();
    bit ok;
    int en_cnt;
    logic [N_REQ-1:0] d;
    do_reset();
    set_sec(0, 2);
    req = 4'b0001;
    wait_state_wait(ok);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    tests++;
    if (!ok || {gnt, done, busy, cur_id, tmr_en} !== 11'd0 || state !== S_IDLE) begin
      fails++;
      $display("FAIL rst_mid: got wait_seen=%0d gnt=%b done=%b busy=%b cur_id=%0d tmr_en=%b state=%0d want all 0",
               ok, gnt, done, busy, cur_id, tmr_en, state);
    end
    rst = 1'b0;
    set_sec(0, 1);
    req = 4'b0001;
    en_cnt = 0; d = '0;
    for (int c = 0; c < 300 && d == '0; c++) begin
      @(negedge clk);
      en_cnt += int'(tmr_en);
      d = done;
    end
    req = '0;
    tests++;
    if (d !== 4'b0001 || en_cnt != 1) begin
      fails++;
      $display("FAIL rst_recover: got done=%b tmr_en=%0d want 0001/1", d, en_cnt);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int done_cnt;
    do_reset();
    set_sec(1, 3);
    req = 4'b0010;
    wait_state_wait(ok);
    req = '0;
`ifdef SCHED_ABORT_EN
    @(negedge clk);
    tests++;
    if (!ok || state !== S_IDLE || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got wait_seen=%0d state=%0d busy=%b want 1/%0d/0",
               ok, state, busy, S_IDLE);
    end
    done_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done != '0) done_cnt++;
    end
    tests++;
    if (done_cnt != 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt);
    end
`else
    done_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done != '0) begin
        done_cnt++;
        tests++;
        if (done !== 4'b0010) begin
          fails++;
          $display("FAIL noabort_done_val: got %b want 0010", done);
        end
      end
    end
    tests++;
    if (!ok || done_cnt != 1) begin
      fails++;
      $display("FAIL noabort_done: got wait_seen=%0d done pulses=%0d want 1/1", ok, done_cnt);
    end
`endif
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_zero_sec();
    test_round_robin();
    test_ptr_wrap();
    test_rst_mid();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
